acc_feeder: RTL

Stream source for the `ACC` floating-point accumulator; sits directly upstream of it in the MAC datapath. Buffers incoming IEEE-754 words in a small FIFO and issues them on the accumulator's `DataInValid`/`DataInRdy`/`DataIn` handshake. Enforces a minimum idle spacing between issued words and tracks accumulation-group boundaries. On request, pads an incomplete group with +0.0 so the accumulator always closes a full group of `AccumulateCount` words.

---
 rtl/acc_feeder_pkg.sv | 13 +
 rtl/acc_feeder_fifo.sv | 54 +++++
 rtl/acc_feeder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/acc_feeder_pkg.sv
// rtl/acc_feeder_pkg.sv - shared feeder state encoding and FP constants
package acc_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } feederState_t;

    // IEEE-754 single +0.0; pad value that leaves an accumulation sum unchanged
    localparam logic [31:0] FpPosZero = 32'h0000_0000;

endpackage

// File: rtl/acc_feeder_fifo.sv
// rtl/acc_feeder_fifo.sv - synchronous FIFO with registered occupancy, no fall-through
module acc_feeder_fifo #(
    parameter int DataWidth     = 32,
    parameter int FifoDepth     = 4,
    parameter int FifoAddrWidth = 2
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   wrEn,
    input  logic [DataWidth-1:0]   wrData,
    input  logic                   rdEn,
    output logic [DataWidth-1:0]   rdData,
    output logic [FifoAddrWidth:0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int LevelWidth = FifoAddrWidth + 1;

    logic [DataWidth-1:0]     mem [FifoDepth];
    logic [FifoAddrWidth-1:0] wrPtr;
    logic [FifoAddrWidth-1:0] rdPtr;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + FifoAddrWidth'(1);
            end
            if (rdEn) begin
                rdPtr <= rdPtr + FifoAddrWidth'(1);
            end
            case ({wrEn, rdEn})
                2'b10:   level <= level + LevelWidth'(1);
                2'b01:   level <= level - LevelWidth'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdData = mem[rdPtr];
    assign full   = (level == LevelWidth'(FifoDepth));
    assign empty  = (level == '0);

endmodule

// File: rtl/acc_feeder.sv
// rtl/acc_feeder.sv - buffered, rate-limited word source for the ACC accumulator
// Tracks group boundaries and pads open groups with +0.0 on Flush.
module acc_feeder
    import acc_feeder_pkg::*;
#(
    parameter int DataWidth            = 32,
    parameter int AccumulateCount      = 2,
    parameter int AccumulateCountWidth = 1,
    parameter int FifoDepth            = 4,
    parameter int FifoAddrWidth        = 2,
    parameter int IssueGap             = 1
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   SrcValid,
    output logic                   SrcRdy,
    input  logic [DataWidth-1:0]   SrcData,
    input  logic                   Flush,
    output logic                   DataOutValid,
    input  logic                   DataOutRdy,
    output logic [DataWidth-1:0]   DataOut,
    output logic                   GroupLast,
    output logic                   FlushDone,
    output logic [FifoAddrWidth:0] Level
);

    localparam int GapWidth = (IssueGap > 1) ? $clog2(IssueGap + 1) : 1;
    localparam logic [AccumulateCountWidth-1:0] LastCnt = AccumulateCountWidth'(AccumulateCount - 1);

    feederState_t                    state, stateNext;
    logic [DataWidth-1:0]            dataOutReg;
    logic [AccumulateCountWidth-1:0] groupCnt, cntNext;
    logic [GapWidth-1:0]             gapCnt, gapNext;
    logic                            flushPend;
    logic                            flushDone;

    logic                 decide;
    logic                 loadHead;
    logic                 loadZero;
    logic                 doneNext;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [DataWidth-1:0] fifoHead;

    assign SrcRdy = ~aclr & ~fifoFull & ~flushPend;

    acc_feeder_fifo #(
        .DataWidth    (DataWidth),
        .FifoDepth    (FifoDepth),
        .FifoAddrWidth(FifoAddrWidth)
    ) u_fifo (
        .clk   (clk),
        .aclr  (aclr),
        .wrEn  (SrcValid & SrcRdy),
        .wrData(SrcData),
        .rdEn  (loadHead),
        .rdData(fifoHead),
        .level (Level),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (aclr) begin
            state      <= IDLE;
            dataOutReg <= '0;
            groupCnt   <= '0;
            gapCnt     <= '0;
            flushPend  <= 1'b0;
            flushDone  <= 1'b0;
        end else begin
            state     <= stateNext;
            groupCnt  <= cntNext;
            gapCnt    <= gapNext;
            flushDone <= doneNext;
            if (loadHead) begin
                dataOutReg <= fifoHead;
            end else if (loadZero) begin
                dataOutReg <= DataWidth'(FpPosZero);
            end
            if (doneNext) begin
                flushPend <= 1'b0;
            end else if (Flush) begin
                flushPend <= 1'b1;
            end
        end
    end

    // The issue decision is shared by IDLE, the last GAP cycle and a gapless transfer,
    // so valid is low for exactly IssueGap cycles between words.
    always_comb begin
        stateNext = state;
        cntNext   = groupCnt;
        gapNext   = gapCnt;
        decide    = 1'b0;
        loadHead  = 1'b0;
        loadZero  = 1'b0;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                decide = 1'b1;
            end
            OFFER: begin
                if (DataOutRdy) begin
                    cntNext = (groupCnt == LastCnt) ? '0 : groupCnt + AccumulateCountWidth'(1);
                    if (IssueGap > 0) begin
                        stateNext = GAP;
                        gapNext   = GapWidth'(IssueGap);
                    end else begin
                        stateNext = IDLE;
                        decide    = 1'b1;
                    end
                end
            end
            GAP: begin
                gapNext = gapCnt - GapWidth'(1);
                if (gapCnt == GapWidth'(1)) begin
                    stateNext = IDLE;
                    decide    = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (decide) begin
            if (!fifoEmpty) begin
                loadHead  = 1'b1;
                stateNext = OFFER;
            end else if (flushPend && (cntNext != '0)) begin
                loadZero  = 1'b1;
                stateNext = OFFER;
            end else if (flushPend) begin
                doneNext  = 1'b1;
            end
        end
    end

    always_comb begin
        DataOutValid = (state == OFFER);
        GroupLast    = (state == OFFER) && (groupCnt == LastCnt);
        DataOut      = dataOutReg;
        FlushDone    = flushDone;
    end

endmodule
